// File: rtl/sigma_delta_update_pipe.sv
// Sigma-delta background/variance update pipeline.
// Stage 1 takes one pixel beat and computes |pixel - background| and the
// stepped background. Stage 2 applies the variance step rule and the motion
// test. A frame phase counter selects which frames update the variance.
// Valid/ready handshake on both sides. Throughput is one beat per cycle.
module sigma_delta_update_pipe #(
  parameter int PIX_W      = 8,
  parameter int N_AMP      = 2,
  parameter int VMIN       = 2,
  parameter int VMAX       = 2**PIX_W - 1,
  parameter int VINIT      = VMIN,
  parameter int VAR_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sof,
  input  logic             init_frame,
  input  logic [PIX_W-1:0] curr_pixel,
  input  logic [PIX_W-1:0] background,
  input  logic [PIX_W-1:0] variance,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] background_next,
  output logic [PIX_W-1:0] variance_next,
  output logic             motion_detected
);

  localparam int PH_W = (VAR_PERIOD > 1) ? $clog2(VAR_PERIOD) : 1;
  // Amplified diff is kept four bits wider so N_AMP up to 15 cannot wrap.
  localparam int XW   = PIX_W + 4;

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(VAR_PERIOD - 1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;
  localparam logic [XW-1:0]    VMIN_X  = XW'(VMIN);
  localparam logic [XW-1:0]    VMAX_X  = XW'(VMAX);
  localparam logic [PIX_W-1:0] VMIN_P  = PIX_W'(VMIN);
  localparam logic [PIX_W-1:0] VMAX_P  = PIX_W'(VMAX);
  localparam logic [PIX_W-1:0] VINIT_P = PIX_W'(VINIT);

  // Handshake
  logic s1_adv;
  logic s2_adv;
  logic accept;

  // Frame phase
  logic [PH_W-1:0] phase_q, phase_d;
  logic [PH_W-1:0] beat_phase;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic             s1_init_q, s1_init_d;
  logic             s1_upd_q, s1_upd_d;
  logic [PIX_W-1:0] s1_diff_q, s1_diff_d;
  logic [PIX_W-1:0] s1_bg_q, s1_bg_d;
  logic [PIX_W-1:0] s1_var_q, s1_var_d;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid_q, s2_valid_d;
  logic [PIX_W-1:0] s2_bg_q, s2_bg_d;
  logic [PIX_W-1:0] s2_var_q, s2_var_d;
  logic             s2_mot_q, s2_mot_d;

  // Stage 1 combinational results
  logic [PIX_W-1:0] in_diff;
  logic [PIX_W-1:0] in_bg_next;

  // Stage 2 combinational results
  logic [XW-1:0]    var_x;
  logic [XW-1:0]    amp_x;
  logic [XW-1:0]    var_adj_x;
  logic [PIX_W-1:0] var_calc;
  logic             mot_calc;

  // Backpressure: stage 2 moves when empty or drained; stage 1 follows it.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    accept   = in_valid && s1_adv;
  end

  // Phase of the incoming beat includes its own sof; only handshakes commit it.
  always_comb begin
    beat_phase = phase_q;
    if (sof) begin
      beat_phase = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end
    phase_d = accept ? beat_phase : phase_q;
  end

  // Absolute difference and one-step background tracking with saturation.
  always_comb begin
    in_diff    = (curr_pixel > background) ? (curr_pixel - background)
                                           : (background - curr_pixel);
    in_bg_next = background;
    if (init_frame) begin
      in_bg_next = curr_pixel;
    end else if (curr_pixel > background) begin
      in_bg_next = (background == PIX_MAX) ? background : background + PIX_W'(1);
    end else if (curr_pixel < background) begin
      in_bg_next = (background == '0) ? background : background - PIX_W'(1);
    end
  end

  // Stage 1 load: valid follows in_valid on advance, payload only on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_init_d  = s1_init_q;
    s1_upd_d   = s1_upd_q;
    s1_diff_d  = s1_diff_q;
    s1_bg_d    = s1_bg_q;
    s1_var_d   = s1_var_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_init_d = init_frame;
      s1_upd_d  = (beat_phase == '0);
      s1_diff_d = in_diff;
      s1_bg_d   = in_bg_next;
      s1_var_d  = variance;
    end
  end

  // Variance step toward N_AMP*diff, clamp, and the motion test on old variance.
  always_comb begin
    var_x     = XW'(s1_var_q);
    amp_x     = XW'(N_AMP) * XW'(s1_diff_q);
    var_adj_x = var_x;
    if (s1_upd_q && (s1_diff_q != '0)) begin
      if (var_x < amp_x) begin
        var_adj_x = var_x + XW'(1);
      end else if (var_x > amp_x) begin
        var_adj_x = var_x - XW'(1);
      end
    end
    if (var_adj_x < VMIN_X) begin
      var_calc = VMIN_P;
    end else if (var_adj_x > VMAX_X) begin
      var_calc = VMAX_P;
    end else begin
      var_calc = var_adj_x[PIX_W-1:0];
    end
    mot_calc = (s1_diff_q >= s1_var_q);
    if (s1_init_q) begin
      var_calc = VINIT_P;
      mot_calc = 1'b0;
    end
  end

  // Stage 2 load: outputs hold while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_bg_d    = s2_bg_q;
    s2_var_d   = s2_var_q;
    s2_mot_d   = s2_mot_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_bg_d  = s1_bg_q;
        s2_var_d = var_calc;
        s2_mot_d = mot_calc;
      end
    end
  end

  // Pipeline and phase registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_LAST;
      s1_valid_q <= 1'b0;
      s1_init_q  <= 1'b0;
      s1_upd_q   <= 1'b0;
      s1_diff_q  <= '0;
      s1_bg_q    <= '0;
      s1_var_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bg_q    <= '0;
      s2_var_q   <= '0;
      s2_mot_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_init_q  <= s1_init_d;
      s1_upd_q   <= s1_upd_d;
      s1_diff_q  <= s1_diff_d;
      s1_bg_q    <= s1_bg_d;
      s1_var_q   <= s1_var_d;
      s2_valid_q <= s2_valid_d;
      s2_bg_q    <= s2_bg_d;
      s2_var_q   <= s2_var_d;
      s2_mot_q   <= s2_mot_d;
    end
  end

  assign out_valid       = s2_valid_q;
  assign background_next = s2_bg_q;
  assign variance_next   = s2_var_q;
  assign motion_detected = s2_mot_q;

endmodule

// File: tb/tb_sigma_delta_update_pipe.sv
// Bench for sigma_delta_update_pipe: two instances (VAR_PERIOD 1 and 2) share
// stimulus; each is scored against a per-beat arithmetic model and a queue.
module tb_sigma_delta_update_pipe;

  localparam int N_AMP = 2;
  localparam int VMIN  = 2;
  localparam int VMAX  = 255;
  localparam int VINIT = 2;
  localparam int P1    = 1;
  localparam int P2    = 2;

  typedef struct {
    int bg;
    int vr;
    int mot;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       sof;
  logic       init_frame;
  logic [7:0] curr_pixel;
  logic [7:0] background;
  logic [7:0] variance;
  logic       out_ready;

  logic       in_ready, out_valid, motion_detected;
  logic [7:0] background_next, variance_next;
  logic       in_ready2, out_valid2, motion_detected2;
  logic [7:0] background_next2, variance_next2;

  sigma_delta_update_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sof(sof), .init_frame(init_frame),
    .curr_pixel(curr_pixel), .background(background), .variance(variance),
    .out_valid(out_valid), .out_ready(out_ready),
    .background_next(background_next), .variance_next(variance_next),
    .motion_detected(motion_detected)
  );

  sigma_delta_update_pipe #(.VAR_PERIOD(P2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .sof(sof), .init_frame(init_frame),
    .curr_pixel(curr_pixel), .background(background), .variance(variance),
    .out_valid(out_valid2), .out_ready(out_ready),
    .background_next(background_next2), .variance_next(variance_next2),
    .motion_detected(motion_detected2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t q1[$];
  res_t q2[$];
  int   ph1, ph2;
  int   last_ov, last_acc, snap_bg, snap_vr, snap_mot, snap_vr2, snap_rdy;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one beat in, one result out, from the update rules directly.
  function automatic res_t model(input int pix, input int bg, input int vr,
                                 input bit ini, input int phase);
    res_t r;
    int   d, a, v;
    if (ini) begin
      r.bg = pix; r.vr = VINIT; r.mot = 0;
      return r;
    end
    d = (pix > bg) ? pix - bg : bg - pix;
    if (pix > bg)      r.bg = (bg == 255) ? 255 : bg + 1;
    else if (pix < bg) r.bg = (bg == 0) ? 0 : bg - 1;
    else               r.bg = bg;
    v = vr;
    if (phase == 0 && d != 0) begin
      a = N_AMP * d;
      if (v < a) v = v + 1;
      else if (v > a) v = v - 1;
    end
    if (v < VMIN) v = VMIN;
    if (v > VMAX) v = VMAX;
    r.vr  = v;
    r.mot = (d >= vr) ? 1 : 0;
    return r;
  endfunction

  // One clock: score outputs and ready at the falling edge, then move inputs.
  task automatic step();
    @(negedge clk);
    last_ov  = int'(out_valid);
    snap_bg  = int'(background_next);
    snap_vr  = int'(variance_next);
    snap_mot = int'(motion_detected);
    snap_vr2 = int'(variance_next2);
    snap_rdy = int'(in_ready);
    chk("in_ready",  int'(in_ready),  int'(q1.size() < 2 || out_ready));
    chk("in_ready2", int'(in_ready2), int'(q2.size() < 2 || out_ready));
    if (out_valid) begin
      if (q1.size() == 0) chk("out_valid_no_beat", int'(out_valid), 0);
      else begin
        chk("bg_next",  int'(background_next), q1[0].bg);
        chk("var_next", int'(variance_next),   q1[0].vr);
        chk("motion",   int'(motion_detected), q1[0].mot);
        if (out_ready) void'(q1.pop_front());
      end
    end
    if (out_valid2) begin
      if (q2.size() == 0) chk("out_valid2_no_beat", int'(out_valid2), 0);
      else begin
        chk("bg_next2",  int'(background_next2), q2[0].bg);
        chk("var_next2", int'(variance_next2),   q2[0].vr);
        chk("motion2",   int'(motion_detected2), q2[0].mot);
        if (out_ready) void'(q2.pop_front());
      end
    end
    last_acc = int'(in_valid && in_ready);
    if (in_valid && in_ready) begin
      if (sof) ph1 = (ph1 + 1) % P1;
      q1.push_back(model(int'(curr_pixel), int'(background), int'(variance),
                         init_frame, ph1));
    end
    if (in_valid && in_ready2) begin
      if (sof) ph2 = (ph2 + 1) % P2;
      q2.push_back(model(int'(curr_pixel), int'(background), int'(variance),
                         init_frame, ph2));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int pix, input int bg, input int vr,
                          input bit ini, input bit s);
    curr_pixel = 8'(pix); background = 8'(bg); variance = 8'(vr);
    init_frame = ini; sof = s;
  endtask

  task automatic send(input int pix, input int bg, input int vr,
                      input bit ini, input bit s);
    int n;
    set_beat(pix, bg, vr, ini, s);
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (last_acc == 0 && n < 20);
    if (last_acc == 0) chk("send_timeout", last_acc, 1);
    in_valid = 1'b0; sof = 1'b0; init_frame = 1'b0;
  endtask

  // Single beat with out_ready high: check 2-cycle latency and fixed values.
  task automatic send_check(input string tag, input int pix, input int bg,
                            input int vr, input bit ini, input bit s,
                            input int ebg, input int evr, input int emot,
                            input int evr2);
    send(pix, bg, vr, ini, s);
    step();
    chk({tag, "_lat1"}, last_ov, 0);
    step();
    chk({tag, "_lat2"}, last_ov, 1);
    chk({tag, "_bg"},   snap_bg, ebg);
    chk({tag, "_var"},  snap_vr, evr);
    chk({tag, "_mot"},  snap_mot, emot);
    chk({tag, "_var2"}, snap_vr2, evr2);
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_q1_left"}, q1.size(), 0);
    chk({tag, "_q2_left"}, q2.size(), 0);
  endtask

  function automatic int rpix();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 255;
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    int acc, k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_beat(0, 0, 0, 1'b0, 1'b0);
    ph1 = P1 - 1; ph2 = P2 - 1;

    #12;
    chk("rst_out_valid",  int'(out_valid), 0);
    chk("rst_out_valid2", int'(out_valid2), 0);
    chk("rst_bg_next",    int'(background_next), 0);
    chk("rst_var_next",   int'(variance_next), 0);
    chk("rst_motion",     int'(motion_detected), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", snap_rdy, 1);

    // Directed beats; dut2 sits in phase 1 until the first sof.
    send_check("basic", 100, 90, 10, 1'b0, 1'b0, 91, 11, 1, 10);
    send_check("sat_hi", 255, 255, 255, 1'b0, 1'b0, 255, 255, 0, 255);
    send_check("vmin", 0, 0, 1, 1'b0, 1'b0, 0, 2, 0, 2);
    send_check("init", 37, 200, 99, 1'b1, 1'b0, 37, 2, 0, 2);
    send_check("frame0", 50, 40, 5, 1'b0, 1'b1, 41, 6, 1, 6);
    send_check("frame1", 50, 40, 5, 1'b0, 1'b1, 41, 6, 1, 5);
    send_check("frame2", 50, 40, 5, 1'b0, 1'b1, 41, 6, 1, 6);
    send_check("frame3", 50, 40, 5, 1'b0, 1'b1, 41, 6, 1, 5);

    // Backpressure: out_ready low for 4 cycles while 5 beats are offered.
    acc = 0; k = 0;
    set_beat(rpix(), rpix(), rpix(), 1'b0, 1'b0);
    in_valid = 1'b1;
    while (acc < 5 && k < 40) begin
      out_ready = (k >= 4);
      step();
      if (k == 2 || k == 3) chk("bp_ready_low", snap_rdy, 0);
      if (last_acc != 0) begin
        acc++;
        set_beat(rpix(), rpix(), rpix(), 1'b0, 1'b0);
      end
      k++;
    end
    chk("bp_accepted", acc, 5);
    drain("bp");

    // Randomized flow with random stalls, frame starts and init beats.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_beat(rpix(), rpix(), rpix(),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      step();
    end
    drain("rand");

    // Reset with two beats in flight.
    out_ready = 1'b0;
    set_beat(120, 60, 30, 1'b0, 1'b1);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0; sof = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid",  int'(out_valid), 0);
    chk("mid_rst_out_valid2", int'(out_valid2), 0);
    chk("mid_rst_bg",         int'(background_next), 0);
    chk("mid_rst_var",        int'(variance_next), 0);
    q1.delete(); q2.delete();
    ph1 = P1 - 1; ph2 = P2 - 1;
    #20;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ready_after_mid_rst", snap_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_out", last_ov, 0);
    end

    // Traffic after reset checks the phase counter restarted correctly.
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_beat(rpix(), rpix(), rpix(), 1'b0, ($urandom_range(0, 3) == 0));
      step();
    end
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sigma_delta_update_pipe.md
SIGMA_DELTA_UPDATE_PIPE -- requirements
Module: sigma_delta_update_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel/background/variance width in bits.
REQ-002 SHALL have parameter N_AMP, default 2, amplification factor applied to diff in the variance rule (1..15).
REQ-003 SHALL have parameter VMIN, default 2, variance lower clamp.
REQ-004 SHALL have parameter VMAX, default 2**PIX_W-1, variance upper clamp (VMIN < VMAX).
REQ-005 SHALL have parameter VINIT, default VMIN, variance written on init beats.
REQ-006 SHALL have parameter VAR_PERIOD, default 1, frames between variance updates (>=1).
REQ-007 SHALL have ports: clk in 1 clock; rst_n in 1 reset.
REQ-008 SHALL have ports: in_valid in 1; in_ready out 1; sof in 1 first pixel of frame; init_frame in 1 load-background mode; curr_pixel in PIX_W; background in PIX_W; variance in PIX_W.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; background_next out PIX_W; variance_next out PIX_W; motion_detected out 1.
REQ-010 SHALL use one clock, clk, with reset rst_n asynchronous and active-low.

Function
REQ-011 SHALL accept a beat when in_valid && in_ready; SHALL emit a result when out_valid && out_ready.
REQ-012 SHALL be a two-stage pipeline: S1 registers inputs, diff=|curr_pixel-background| and background_next; S2 registers variance_next and motion_detected.
REQ-013 SHALL advance S2 when !s2_valid || out_ready, and advance S1 when !s1_valid || S2 advances; in_ready SHALL equal the S1 advance condition (combinational from out_ready).
REQ-014 SHALL give latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high; throughput 1 beat/cycle.
REQ-015 SHALL hold all outputs stable while out_valid && !out_ready; SHALL never drop or duplicate a beat.
REQ-016 SHALL, on normal beats, set background_next = background+1 if curr_pixel > background, background-1 if <, else unchanged; saturating at 2**PIX_W-1 and 0.
REQ-017 SHALL compute N_AMP*diff at full width (PIX_W+4 bits), with no truncation before comparison.
REQ-018 SHALL, on a variance-update beat with diff != 0, set variance_next = variance+1 if variance < N_AMP*diff, variance-1 if variance > N_AMP*diff, then clamp to [VMIN, VMAX]; otherwise variance_next = variance clamped to [VMIN, VMAX].
REQ-019 SHALL set motion_detected = (diff >= variance), using the input variance, not variance_next.
REQ-020 SHALL, on init_frame beats, set background_next = curr_pixel, variance_next = VINIT and motion_detected = 0, regardless of the phase counter.
REQ-021 SHALL keep a frame phase counter of range 0..VAR_PERIOD-1; an accepted beat with sof=1 SHALL advance it, wrapping from VAR_PERIOD-1 to 0; the beat's own phase is the value after its sof is applied.
REQ-022 SHALL treat a beat as a variance-update beat only when its phase == 0; beats in other phases SHALL pass variance through, clamped.
REQ-023 SHALL ignore sof on beats that are not accepted; the counter SHALL change only on handshake.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear s1_valid, s2_valid, out_valid, motion_detected, background_next and variance_next to 0, and set the phase counter to VAR_PERIOD-1, so that the first sof frame is phase 0.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset release; a reset asserted mid-stream SHALL discard all in-flight beats.

Verification
REQ-026 Defaults, continuous flow: pixel=100, bg=90, var=10 -> 2 cycles later bg_next=91, var_next=11 (20>10), motion=1.
REQ-027 Saturation: pixel=255, bg=255, var=255 -> bg_next=255, var_next=255 (diff=0, clamp); pixel=0, bg=0, var=1 -> var_next=2 (VMIN clamp), motion=0.
REQ-028 Init: init_frame=1, pixel=37, bg=200 -> bg_next=37, var_next=2, motion=0.
REQ-029 Backpressure: 5 beats accepted, out_ready low for 4 cycles -> in_ready falls after S1/S2 fill, outputs held stable, all 5 results in order, none lost.
REQ-030 VAR_PERIOD=2: frames 0..3 each start with sof; pixel=50, bg=40, var=5 -> var_next=6 in frames 0 and 2, var_next=5 in frames 1 and 3.
REQ-031 Reset mid-stream: drop rst_n with 2 beats in flight -> out_valid=0 immediately, no stale output after release.
